// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC sequencing, I-mem handshake, redirect/stall handling.
// Optional MISALIGNED_TARGET_TRAP_EN adds a sticky trap on misaligned redirect targets.
module instruction_fetch_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_MUX_SEL,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTR,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  output logic        FLUSH
`ifdef MISALIGNED_TARGET_TRAP_EN
  ,
  output logic        FETCH_MISALIGNED
`endif
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] hold_buf;
  logic        discard;
  logic        trap;
  logic        bad_redirect;
  logic        accept;
  logic [31:0] target;
  logic [31:0] addr_plus4;

`ifdef MISALIGNED_TARGET_TRAP_EN
  assign bad_redirect = PC_MUX_SEL && (BRANCH_TARGET[1:0] != 2'b00);

  always_ff @(posedge CLK) begin
    if (RESET)
      trap <= 1'b0;
    else if (bad_redirect)
      trap <= 1'b1;
  end

  assign FETCH_MISALIGNED = trap;
`else
  assign bad_redirect = 1'b0;
  assign trap         = 1'b0;
`endif

  // Low target bits are ignored: targets are always word aligned here.
  assign target     = BRANCH_TARGET & ~32'h3;

  assign IMEM_READ  = (state != HOLD) && !trap;
  assign IMEM_ADDR  = (state == WAIT) ? fetch_addr : pc;
  assign accept     = IMEM_READ && !IMEM_BUSYWAIT;
  assign addr_plus4 = IMEM_ADDR + 32'd4;
  assign FLUSH      = PC_MUX_SEL;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= FETCH;
      pc          <= '0;
      fetch_addr  <= '0;
      hold_buf    <= '0;
      discard     <= 1'b0;
      INSTR       <= '0;
      INSTR_PC    <= '0;
      INSTR_VALID <= 1'b0;
    end else if (trap || bad_redirect) begin
      // Trapped: the stage is frozen until reset, only bubbles leave it.
      INSTR_VALID <= 1'b0;
    end else if (PC_MUX_SEL) begin
      pc          <= target;
      INSTR_VALID <= 1'b0;
      if (accept) begin
        discard <= 1'b0;
        state   <= FETCH;
      end else if (state == WAIT || state == FETCH) begin
        // A request is in flight; let it complete at its address and drop it.
        discard <= 1'b1;
        if (state == FETCH)
          fetch_addr <= pc;
        state <= WAIT;
      end else begin
        state <= FETCH;
      end
    end else if (accept) begin
      if (discard) begin
        discard <= 1'b0;
        state   <= FETCH;
        if (!STALL)
          INSTR_VALID <= 1'b0;
      end else if (!STALL) begin
        INSTR       <= IMEM_INSTR;
        INSTR_PC    <= IMEM_ADDR;
        INSTR_VALID <= 1'b1;
        pc          <= addr_plus4;
        state       <= FETCH;
      end else begin
        hold_buf <= IMEM_INSTR;
        pc       <= addr_plus4;
        state    <= HOLD;
      end
    end else begin
      case (state)
        FETCH: begin
          fetch_addr <= pc;
          state      <= WAIT;
          if (!STALL)
            INSTR_VALID <= 1'b0;
        end
        WAIT: begin
          if (!STALL)
            INSTR_VALID <= 1'b0;
        end
        HOLD: begin
          // pc already points past the buffered word.
          if (!STALL) begin
            INSTR       <= hold_buf;
            INSTR_PC    <= pc - 32'd4;
            INSTR_VALID <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
